// File: rtl/hazard_forward_ctrl_if.sv
// Signal bundle between the ID/EX pipeline and the hazard/forwarding controller.
interface hazard_forward_ctrl_if #(
  parameter int unsigned NSRC   = 2,
  parameter int unsigned NFWD   = 2,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned SELW   = $clog2(NFWD + 1)
);
  logic [NSRC*REG_AW-1:0] ex_src;
  logic [NFWD*REG_AW-1:0] fwd_dest;
  logic [NFWD-1:0]        fwd_wen;
  logic [NSRC*SELW-1:0]   fwd_sel;
  logic [NSRC*REG_AW-1:0] id_src;
  logic [NSRC-1:0]        id_src_used;
  logic                   ex_is_load;
  logic [REG_AW-1:0]      ex_dest;
  logic                   ex_wen;
  logic                   id_issue_long;
  logic [REG_AW-1:0]      id_dest;
  logic                   long_done;
  logic [REG_AW-1:0]      long_dest;
  logic                   flush;
  logic                   stall_id;
  logic                   bubble_ex;
  logic [2**REG_AW-1:0]   sb_busy;

  modport master (
    output ex_src, fwd_dest, fwd_wen, id_src, id_src_used, ex_is_load, ex_dest, ex_wen,
           id_issue_long, id_dest, long_done, long_dest, flush,
    input  fwd_sel, stall_id, bubble_ex, sb_busy
  );

  modport slave (
    input  ex_src, fwd_dest, fwd_wen, id_src, id_src_used, ex_is_load, ex_dest, ex_wen,
           id_issue_long, id_dest, long_done, long_dest, flush,
    output fwd_sel, stall_id, bubble_ex, sb_busy
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Operand forwarding select, load-use stall FSM and long-latency register scoreboard.
// Forward selects and stall/bubble are combinational; only FSM and scoreboard are state.
module hazard_forward_ctrl #(
  parameter int unsigned NSRC   = 2,
  parameter int unsigned NFWD   = 2,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned LD_LAT = 2
) (
  input logic             clk,
  input logic             rst_n,
  hazard_forward_ctrl_if.slave bus
);
  localparam int unsigned SELW = $clog2(NFWD + 1);
  localparam int unsigned NREG = 2**REG_AW;
  localparam int unsigned CNTW = (LD_LAT < 4) ? 2 : $clog2(LD_LAT);

  typedef enum logic [0:0] {ST_RUN, ST_LD_WAIT} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNTW-1:0]     r_ld_cnt, w_ld_cnt_nxt;
  logic [NREG-1:0]     r_sb_busy, w_sb_nxt;
  logic [NSRC*SELW-1:0] w_fwd_sel;
  logic                w_src_match;
  logic                w_ld_use;
  logic                w_sb_haz;
  logic                w_fsm_stall;
  logic                w_stall;
  logic                w_sb_set;

  // Per operand: descending scan so the youngest matching producer overwrites older ones
  always_comb begin
    w_fwd_sel = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      for (int k = int'(NFWD); k >= 1; k--) begin
        if (bus.fwd_wen[k-1] &&
            (bus.fwd_dest[(k-1)*REG_AW +: REG_AW] == bus.ex_src[i*REG_AW +: REG_AW]) &&
            (bus.fwd_dest[(k-1)*REG_AW +: REG_AW] != '0)) begin
          w_fwd_sel[i*SELW +: SELW] = SELW'(k);
        end
      end
    end
  end

  // Load-use and scoreboard (RAW + WAW) hazard detection
  always_comb begin
    w_src_match = 1'b0;
    w_sb_haz    = 1'b0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (bus.id_src_used[i] && (bus.id_src[i*REG_AW +: REG_AW] == bus.ex_dest)) begin
        w_src_match = 1'b1;
      end
      if (bus.id_src_used[i] && r_sb_busy[bus.id_src[i*REG_AW +: REG_AW]]) begin
        w_sb_haz = 1'b1;
      end
    end
    if (bus.id_issue_long && r_sb_busy[bus.id_dest]) begin
      w_sb_haz = 1'b1;
    end
    w_ld_use = bus.ex_is_load && bus.ex_wen && (bus.ex_dest != '0) && w_src_match;
  end

  // Load-use FSM next state
  always_comb begin
    w_state_nxt  = r_state;
    w_ld_cnt_nxt = r_ld_cnt;
    w_fsm_stall  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_ld_use) begin
          w_fsm_stall = 1'b1;
          if (LD_LAT > 1) begin
            w_state_nxt  = ST_LD_WAIT;
            w_ld_cnt_nxt = CNTW'(LD_LAT - 1);
          end
        end
      end
      ST_LD_WAIT: begin
        w_fsm_stall  = 1'b1;
        w_ld_cnt_nxt = r_ld_cnt - CNTW'(1);
        if (r_ld_cnt == CNTW'(1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
    if (bus.flush) begin
      w_state_nxt  = ST_RUN;
      w_ld_cnt_nxt = '0;
    end
  end

  assign w_stall = !bus.flush && (w_fsm_stall || w_sb_haz);
  assign w_sb_set = bus.id_issue_long && !w_stall && !bus.flush && (bus.id_dest != '0);

  // Scoreboard next value: clear first so a same-cycle set on the same reg wins
  always_comb begin
    w_sb_nxt = r_sb_busy;
    if (bus.long_done) begin
      w_sb_nxt[bus.long_dest] = 1'b0;
    end
    if (w_sb_set) begin
      w_sb_nxt[bus.id_dest] = 1'b1;
    end
    w_sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_ld_cnt  <= '0;
      r_sb_busy <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ld_cnt  <= w_ld_cnt_nxt;
      r_sb_busy <= w_sb_nxt;
    end
  end

  assign bus.fwd_sel   = w_fwd_sel;
  assign bus.stall_id  = w_stall;
  assign bus.bubble_ex = w_stall;
  assign bus.sb_busy   = r_sb_busy;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench: driver queues expected outputs per cycle, monitor checks them at negedge.
module tb_hazard_forward_ctrl;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  hazard_forward_ctrl_if #(.NSRC(2), .NFWD(2), .REG_AW(5)) bus ();

  hazard_forward_ctrl #(.NSRC(2), .NFWD(2), .REG_AW(5), .LD_LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    logic [3:0] fwd;
    logic       stall;
    int         sb_reg;   // -1 skip, -2 whole vector zero, else bit index
    logic       sb_val;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input string what, input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, what, act, want);
    end
  endtask

  // Monitor: outputs are combinational, so every queued expectation is checked mid-cycle
  always @(negedge clk) begin
    exp_t e;
    while (q.size() != 0) begin
      e = q.pop_front();
      chk(e.tag, "fwd_sel", {28'b0, bus.fwd_sel}, {28'b0, e.fwd});
      chk(e.tag, "stall_id", {31'b0, bus.stall_id}, {31'b0, e.stall});
      chk(e.tag, "bubble_ex", {31'b0, bus.bubble_ex}, {31'b0, e.stall});
      if (e.sb_reg == -2)
        chk(e.tag, "sb_busy", bus.sb_busy, 32'b0);
      else if (e.sb_reg >= 0)
        chk(e.tag, "sb_bit", {31'b0, bus.sb_busy[e.sb_reg]}, {31'b0, e.sb_val});
    end
  end

  task automatic idle();
    bus.ex_src        = '0;
    bus.fwd_dest      = '0;
    bus.fwd_wen       = '0;
    bus.id_src        = '0;
    bus.id_src_used   = '0;
    bus.ex_is_load    = 1'b0;
    bus.ex_dest       = '0;
    bus.ex_wen        = 1'b0;
    bus.id_issue_long = 1'b0;
    bus.id_dest       = '0;
    bus.long_done     = 1'b0;
    bus.long_dest     = '0;
    bus.flush         = 1'b0;
  endtask

  task automatic cyc(input string tag, input logic [3:0] f, input logic s,
                     input int sr, input logic sv);
    exp_t e;
    e.tag = tag; e.fwd = f; e.stall = s; e.sb_reg = sr; e.sb_val = sv;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic load_x3_src0();
    bus.ex_is_load = 1'b1; bus.ex_wen = 1'b1; bus.ex_dest = 5'd3;
    bus.id_src = {5'd0, 5'd3}; bus.id_src_used = 2'b01;
  endtask

  task automatic ex_bubble();
    bus.ex_is_load = 1'b0; bus.ex_wen = 1'b0; bus.ex_dest = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    #1;

    // Reset: scoreboard clear, stall follows only the comb load-use term
    cyc("reset", 4'b0000, 1'b0, -2, 1'b0);
    load_x3_src0();
    cyc("rst_lduse", 4'b0000, 1'b1, -2, 1'b0);
    idle();
    cyc("rst_idle", 4'b0000, 1'b0, -2, 1'b0);
    rst_n = 1'b1;
    cyc("run_idle", 4'b0000, 1'b0, -2, 1'b0);

    // Forwarding priority
    bus.ex_src = {5'd0, 5'd5}; bus.fwd_dest = {5'd5, 5'd5}; bus.fwd_wen = 2'b11;
    cyc("fwd_young", 4'b0001, 1'b0, -1, 1'b0);
    bus.ex_src = {5'd5, 5'd5};
    cyc("fwd_both", 4'b0101, 1'b0, -1, 1'b0);
    bus.fwd_wen = 2'b10;
    cyc("fwd_old", 4'b1010, 1'b0, -1, 1'b0);
    bus.ex_src = {5'd9, 5'd5}; bus.fwd_dest = {5'd9, 5'd5}; bus.fwd_wen = 2'b11;
    cyc("fwd_mix", 4'b1001, 1'b0, -1, 1'b0);
    bus.ex_src = '0; bus.fwd_dest = '0;
    cyc("fwd_zero", 4'b0000, 1'b0, -1, 1'b0);
    bus.ex_src = {5'd5, 5'd5}; bus.fwd_dest = {5'd5, 5'd5}; bus.fwd_wen = 2'b00;
    cyc("fwd_nowen", 4'b0000, 1'b0, -1, 1'b0);
    idle();

    // Load-use: exactly LD_LAT=2 stall cycles
    load_x3_src0();
    cyc("ld_hit", 4'b0000, 1'b1, -1, 1'b0);
    ex_bubble();
    cyc("ld_wait", 4'b0000, 1'b1, -1, 1'b0);
    cyc("ld_release", 4'b0000, 1'b0, -1, 1'b0);
    load_x3_src0();
    bus.id_src = {5'd3, 5'd0}; bus.id_src_used = 2'b01;
    cyc("ld_unused", 4'b0000, 1'b0, -1, 1'b0);
    load_x3_src0();
    bus.ex_wen = 1'b0;
    cyc("ld_nowen", 4'b0000, 1'b0, -1, 1'b0);
    load_x3_src0();
    bus.ex_dest = 5'd0; bus.id_src = '0;
    cyc("ld_x0", 4'b0000, 1'b0, -1, 1'b0);
    load_x3_src0();
    bus.id_src = {5'd3, 5'd4}; bus.id_src_used = 2'b10;
    cyc("ld_op1", 4'b0000, 1'b1, -1, 1'b0);
    ex_bubble();
    cyc("ld_op1_wait", 4'b0000, 1'b1, -1, 1'b0);
    cyc("ld_op1_rel", 4'b0000, 1'b0, -1, 1'b0);
    idle();

    // Long-latency RAW on x7
    bus.id_issue_long = 1'b1; bus.id_dest = 5'd7;
    cyc("lg_issue", 4'b0000, 1'b0, 7, 1'b0);
    idle();
    bus.id_src = {5'd0, 5'd7}; bus.id_src_used = 2'b01;
    cyc("lg_raw", 4'b0000, 1'b1, 7, 1'b1);
    cyc("lg_raw2", 4'b0000, 1'b1, 7, 1'b1);
    bus.long_done = 1'b1; bus.long_dest = 5'd7;
    cyc("lg_done", 4'b0000, 1'b1, 7, 1'b1);
    bus.long_done = 1'b0;
    cyc("lg_rel", 4'b0000, 1'b0, 7, 1'b0);
    idle();

    // WAW: issue to busy x7 stalls while the completion clears it
    bus.id_issue_long = 1'b1; bus.id_dest = 5'd7;
    cyc("w_issue", 4'b0000, 1'b0, 7, 1'b0);
    bus.long_done = 1'b1; bus.long_dest = 5'd7;
    cyc("w_waw", 4'b0000, 1'b1, 7, 1'b1);
    bus.long_done = 1'b0;
    cyc("w_reissue", 4'b0000, 1'b0, 7, 1'b0);
    idle();
    cyc("w_set", 4'b0000, 1'b0, 7, 1'b1);

    // Same-cycle set and clear of x8: set wins; x0 never marked
    bus.id_issue_long = 1'b1; bus.id_dest = 5'd8;
    bus.long_done = 1'b1; bus.long_dest = 5'd8;
    cyc("sw_same", 4'b0000, 1'b0, 8, 1'b0);
    idle();
    cyc("sw_check", 4'b0000, 1'b0, 8, 1'b1);
    bus.long_done = 1'b1; bus.long_dest = 5'd8;
    cyc("sw_clr", 4'b0000, 1'b0, 8, 1'b1);
    idle();
    cyc("sw_clr2", 4'b0000, 1'b0, 8, 1'b0);
    bus.id_issue_long = 1'b1; bus.id_dest = 5'd0;
    cyc("x0_issue", 4'b0000, 1'b0, -1, 1'b0);
    idle();
    cyc("x0_chk", 4'b0000, 1'b0, 0, 1'b0);

    // Flush during LD_WAIT and with a scoreboard hazard
    load_x3_src0();
    cyc("fl_hit", 4'b0000, 1'b1, -1, 1'b0);
    ex_bubble();
    bus.flush = 1'b1;
    cyc("fl_flush", 4'b0000, 1'b0, -1, 1'b0);
    idle();
    cyc("fl_after", 4'b0000, 1'b0, 7, 1'b1);
    bus.flush = 1'b1;
    bus.id_src = {5'd0, 5'd7}; bus.id_src_used = 2'b01;
    bus.id_issue_long = 1'b1; bus.id_dest = 5'd9;
    cyc("fl_sb", 4'b0000, 1'b0, 9, 1'b0);
    idle();
    cyc("fl_noset", 4'b0000, 1'b0, 9, 1'b0);

    // Async reset in the middle of a scoreboard stall
    bus.id_src = {5'd0, 5'd7}; bus.id_src_used = 2'b01;
    cyc("pre_rst", 4'b0000, 1'b1, 7, 1'b1);
    rst_n = 1'b0;
    #1;
    cyc("mid_rst", 4'b0000, 1'b0, -2, 1'b0);
    rst_n = 1'b1;
    cyc("post_rst", 4'b0000, 1'b0, -2, 1'b0);
    idle();

    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
